// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 multicycle controller: state encoding,
// opcode patterns, and the ALU and datapath select codes.
package legv8_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_ADDR,
    S_MEM_RD,
    S_WB_LD,
    S_MEM_WR,
    S_CBZ,
    S_BR,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_CBZ,
    CLS_B,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100000;
  localparam logic [10:0] CBZ_MASK = 11'b11111111000;
  localparam logic [10:0] OP_B     = 11'b00010100000;
  localparam logic [10:0] B_MASK   = 11'b11111100000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] ALUSRCB_REG      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR     = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM      = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SHL2 = 2'b11;

  // Opcodes whose low bits carry part of an immediate match only under a mask.
  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pattern,
                                    input logic [10:0] mask);
    return (op & mask) == (pattern & mask);
  endfunction

endpackage

// File: rtl/legv8_opcode_class.sv
// Classifies the 11-bit LEGv8 opcode field into the instruction groups the
// controller dispatches on.
module legv8_opcode_class
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      op_class = CLS_RTYPE;
    else if (opcode == OP_LDUR)
      op_class = CLS_LOAD;
    else if (opcode == OP_STUR)
      op_class = CLS_STORE;
    else if (op_match(opcode, OP_CBZ, CBZ_MASK))
      op_class = CLS_CBZ;
    else if (op_match(opcode, OP_B, B_MASK))
      op_class = CLS_B;
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Moore controller for the shared LEGv8 multicycle datapath, with memory-ready
// stalls, an illegal-opcode trap and a retired-instruction counter.
//
// state    | meaning
// RST      | post-reset idle, all controls low
// FETCH    | read instruction, load IR, PC+4 when memory is ready
// DECODE   | branch target into ALUOut, dispatch on opcode class
// EXEC_R   | R-type ALU operation on A and B
// WB_R     | write ALU result to register file
// ADDR     | effective address A + sign-extended offset
// MEM_RD   | data read, waits for mem_ready
// WB_LD    | write MDR to register file
// MEM_WR   | data write, waits for mem_ready
// CBZ      | pass B through ALU, PC <= ALUOut if zero
// BR       | PC <= ALUOut
// TRAP     | unsupported opcode, halted until reset
module legv8_multicycle_control
  import legv8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ALUOp1,
  output logic             ALUOp0,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             Reg2Loc,
  output logic             halt,
  output logic [CNT_W-1:0] instr_count
);

  state_t    state;
  state_t    state_nxt;
  op_class_t op_class;
  logic      retire;
  logic [1:0] alu_op;

  // The zero flag gates the PC load in the datapath, not in this FSM.
  logic unused_zero;
  assign unused_zero = zero;

  legv8_opcode_class u_opcode_class (
    .opcode   (opcode),
    .op_class (op_class)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_RST;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op_class)
          CLS_RTYPE:             state_nxt = S_EXEC_R;
          CLS_LOAD, CLS_STORE:   state_nxt = S_ADDR;
          CLS_CBZ:               state_nxt = S_CBZ;
          CLS_B:                 state_nxt = S_BR;
          default:               state_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R: state_nxt = S_WB_R;
      S_WB_R: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_ADDR:   state_nxt = (op_class == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_nxt = S_WB_LD;
      S_WB_LD: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_CBZ, S_BR: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_RST;
    endcase
  end

  always_comb begin
    alu_op      = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUSRCB_REG;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    Reg2Loc     = 1'b0;
    halt        = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = ALUSRCB_FOUR;
        // PC+4 lands only once the fetch actually completes.
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = ALUSRCB_IMM_SHL2;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_RTYPE;
      end
      S_WB_R:   RegWrite = 1'b1;
      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
        Reg2Loc = 1'b1;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_LD: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
      end
      S_CBZ: begin
        ALUSrcA     = 1'b1;
        alu_op      = ALUOP_PASSB;
        Reg2Loc     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      S_BR: begin
        PCWrite  = 1'b1;
        PCSource = 1'b1;
      end
      S_TRAP:   halt = 1'b1;
      default:  ;
    endcase
  end

  assign ALUOp1 = alu_op[1];
  assign ALUOp0 = alu_op[0];

endmodule

// File: doc/legv8_multicycle_control.md
# legv8_multicycle_control

- Moore finite-state controller that sequences the shared LEGv8 multicycle datapath: the single ALU, the unified instruction/data memory port, the IR, the PC and the register file.
- Decodes the instruction opcode field and walks each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUOp to the ALU control decoder.
- Stalls on a memory-ready handshake, traps on unsupported opcodes and counts retired instructions.

## Interface

- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: synchronous, active-low reset; one clock; sampled on `clk` rising edge.
- `opcode` input 11: IR[31:21], valid from DECODE onward.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current read or write this cycle.
- `ALUOp1`, `ALUOp0` output 1 each: ALU control select. 00 = add, 01 = pass-B, 10 = R-type function.
- `ALUSrcA` output 1: 0 = PC, 1 = register A.
- `ALUSrcB` output 2: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `PCWrite`, `PCWriteCond` output 1 each: unconditional PC load; PC load when `zero` is 1.
- `PCSource` output 1: 0 = ALU result, 1 = ALUOut.
- `IorD` output 1: memory address source, 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`, `IRWrite` output 1 each: memory read, memory write, IR load.
- `RegWrite`, `MemtoReg`, `Reg2Loc` output 1 each: register-file write, writeback source (1 = MDR), read-port-2 select (1 = Rt).
- `halt` output 1: sticky, asserted in TRAP.
- `instr_count` output CNT_W: count of retired instructions.

## Operation

- States: RST, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LD, MEM_WR, CBZ, BR, TRAP.
- RST: all outputs 0; `instr_count` = 0. Always goes to FETCH next cycle.
- FETCH: `MemRead`=1, `IorD`=0, `IRWrite`=1, `ALUSrcA`=0, `ALUSrcB`=01, ALUOp=00, `PCWrite`=`mem_ready`.
  - Stays in FETCH while `mem_ready`=0.
  - Goes to DECODE when `mem_ready`=1.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, ALUOp=00. Computes the branch target into ALUOut. Opcode dispatch:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 → EXEC_R.
  - LDUR 11111000010, STUR 11111000000 → ADDR.
  - CBZ 10110100xxx → CBZ.
  - B 000101xxxxx → BR.
  - Any other opcode → TRAP.
- EXEC_R: `ALUSrcA`=1, `ALUSrcB`=00, ALUOp=10 → WB_R.
- WB_R: `RegWrite`=1, `MemtoReg`=0; retires → FETCH.
- ADDR: `ALUSrcA`=1, `ALUSrcB`=10, ALUOp=00, `Reg2Loc`=1.
  - LDUR → MEM_RD.
  - STUR → MEM_WR.
- MEM_RD: `MemRead`=1, `IorD`=1. Waits for `mem_ready`, then → WB_LD.
- WB_LD: `RegWrite`=1, `MemtoReg`=1; retires → FETCH.
- MEM_WR: `MemWrite`=1, `IorD`=1, `Reg2Loc`=1. Waits for `mem_ready`; retires → FETCH.
- CBZ: `ALUSrcA`=1, `ALUSrcB`=00, ALUOp=01, `Reg2Loc`=1, `PCWriteCond`=1, `PCSource`=1; retires → FETCH.
- BR: `PCWrite`=1, `PCSource`=1; retires → FETCH.
- TRAP: `halt`=1, all other controls 0. Leaves TRAP only through reset.
- Retire: `instr_count` increments by 1 on the transition into FETCH out of WB_R, WB_LD, MEM_WR, CBZ or BR. It wraps modulo 2^CNT_W with no saturation.
- Any output not listed for a state is 0.

## Timing

- All outputs are decoded combinationally from the state register only. `PCWrite` in FETCH is the one exception: it is gated by `mem_ready`.
- The state register and `instr_count` update on the `clk` rising edge.
- Cycles per instruction when `mem_ready` is tied to 1:
  - R-type: 4.
  - LDUR: 5.
  - STUR: 4.
  - CBZ, B: 3.
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. No control output changes during a stall.
- Reset mid-instruction: the next state is RST; `instr_count` clears; `halt` clears. An in-flight store in MEM_WR is abandoned, and `MemWrite` is 0 in the cycle after reset is sampled.
- `reset_n` low overrides every transition, including TRAP.
- Counter wrap and retire in the same cycle: the all-ones value goes to 0.

## Structure

- Shared package `legv8_pkg`:
  - state enum.
  - opcode constants and masks: `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_ORR`, `OP_LDUR`, `OP_STUR`, `OP_CBZ`/`CBZ_MASK`, `OP_B`/`B_MASK`.
  - ALUOp constants: `ALUOP_ADD`, `ALUOP_PASSB`, `ALUOP_RTYPE`.
  - ALUSrcB select constants.
- Sub-module `legv8_opcode_class`: combinational mapping from opcode to class {RTYPE, LOAD, STORE, CBZ, B, ILLEGAL}. The controller uses it in DECODE and to choose the ADDR successor.
- Top level: state register, next-state logic, output decode, retire counter.

## Test plan

- Reset, then ADD opcode 10001011000 with `mem_ready`=1 → states FETCH, DECODE, EXEC_R, WB_R. ALUOp=10 in EXEC_R. `RegWrite`=1 for one cycle. `instr_count`=1 after 4 cycles.
- LDUR with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEM_RD → 10 cycles total. `MemRead`, `IorD` and `IRWrite` stay stable during each stall. Exactly one `PCWrite` pulse.
- CBZ 10110100101 → ALUOp=01, `PCWriteCond`=1, `PCSource`=1 in the third cycle, then FETCH. Then B 00010100000 → `PCWrite`=1 in BR. `instr_count` advances by 2.
- Illegal opcode 11111111111 → TRAP after DECODE. `halt`=1, all other outputs 0 for 20 cycles. Reset → RST, then FETCH. `halt`=0.
- `reset_n` driven low in MEM_WR while `mem_ready`=0 → RST on the next edge, `MemWrite`=0, `instr_count`=0.
- CNT_W=4 with 16 back-to-back B instructions → `instr_count` wraps from 15 to 0.
